// File: rtl/perf_pkg.sv
// perf_pkg -- shared definitions for the performance monitor.
//
// Holds the two-state FSM encoding, the default parameter values used by
// perf_monitor and perf_counter, and the bit positions inside the status word.
//
// Configuration macro: PERF_SAT_EN (consumed by perf_counter).

package perf_pkg;

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam int DEF_NUM_CH      = 8;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_IDLE_CYCLES = 50;

    // Readout address width and status-word layout.
    localparam int ADDR_W        = 5;
    localparam int STAT_OVF_BIT  = 0;
    localparam int STAT_DONE_BIT = 1;

endpackage

// File: rtl/perf_counter.sv
// perf_counter -- one accumulating counter with a sticky overflow flag.
//
// Adds a 0..3 increment each enabled cycle. A carry out of CNT_W bits sets
// ovf, which stays set until clr or reset.
//
// Configuration macro: PERF_SAT_EN
//   defined   : the count saturates at all-ones on a carry
//   undefined : the count wraps modulo 2^CNT_W
//
// Ports:
//   CLK   in   clock, rising edge
//   nrst  in   asynchronous active-low reset
//   clr   in   synchronous clear of count and ovf (wins over en)
//   en    in   accumulate enable
//   inc   in   increment amount 0..3
//   cnt   out  current count
//   ovf   out  sticky overflow flag

module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             nrst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W:0]   sum;
    logic             carry;
    logic [CNT_W-1:0] next_val;

    // One extra bit captures the carry out of the add.
    assign sum   = {1'b0, cnt} + {{(CNT_W - 1){1'b0}}, inc};
    assign carry = sum[CNT_W];

`ifdef PERF_SAT_EN
    assign next_val = carry ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
    assign next_val = sum[CNT_W-1:0];
`endif

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            cnt <= next_val;
            if (carry) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor -- event counters with program-completion detection.
//
// NUM_CH event channels accumulate evt_inc while in COUNT, alongside a
// cycle counter. When the fetched instruction stays unchanged for
// IDLE_CYCLES consecutive cycles the program is deemed finished and the
// FSM enters DONE, freezing all counters until clr. A registered readout
// port selects a channel, the cycle count or the status word.
//
// Handshake: none; rd_addr is sampled every cycle and rd_data shows the
// selected value one cycle later.
//
// Configuration macro: PERF_SAT_EN (saturating counters; wrap otherwise).
//
// Ports:
//   CLK      in   clock, rising edge
//   nrst     in   asynchronous active-low reset
//   inst     in   fetched instruction word (idle detection)
//   evt_inc  in   per-channel increment, channel k at [2k+1:2k]
//   clr      in   synchronous clear of counters, flags and idle detector
//   rd_addr  in   0..NUM_CH-1 channel, NUM_CH cycles, NUM_CH+1 status
//   rd_data  out  registered readout value
//   done     out  high while in DONE (this is the FSM state itself)
//   ovf      out  sticky per-channel overflow flags

module perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic                CLK,
    input  logic                nrst,
    input  logic [31:0]         inst,
    input  logic [2*NUM_CH-1:0] evt_inc,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CNT_W-1:0]    rd_data,
    output logic                done,
    output logic [NUM_CH-1:0]   ovf
);

    localparam logic [7:0]       IDLE_LIM = 8'(IDLE_CYCLES);
    localparam logic [7:0]       IDLE_M1  = 8'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_W   = CNT_W'(IDLE_CYCLES);

    state_t           state;
    logic [7:0]       idle_cnt;
    logic [31:0]      last_inst;
    logic             counting;
    logic             inst_match;
    logic [CNT_W-1:0] ch_cnt [NUM_CH];
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_adj;
    logic             cyc_ovf_unused;
    logic [CNT_W-1:0] rd_next;

    assign counting   = (state == ST_COUNT);
    assign inst_match = (inst == last_inst);
    assign done       = (state == ST_DONE);

    // Event channels.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .CLK  (CLK),
            .nrst (nrst),
            .clr  (clr),
            .en   (counting),
            .inc  (evt_inc[2*k +: 2]),
            .cnt  (ch_cnt[k]),
            .ovf  (ovf[k])
        );
    end

    // Cycle counter: same counter with a constant increment of one.
    perf_counter #(.CNT_W(CNT_W)) u_cycle (
        .CLK  (CLK),
        .nrst (nrst),
        .clr  (clr),
        .en   (counting),
        .inc  (2'd1),
        .cnt  (cyc_cnt),
        .ovf  (cyc_ovf_unused)
    );

    // Idle detector and FSM. The transition fires on the edge where
    // idle_cnt reaches IDLE_CYCLES, so DONE is visible in the very next
    // cycle. idle_cnt saturates at the limit so it cannot wrap in DONE.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_COUNT;
            idle_cnt  <= '0;
            last_inst <= '0;
        end else if (clr) begin
            state     <= ST_COUNT;
            idle_cnt  <= '0;
            last_inst <= '0;
        end else begin
            if (inst_match) begin
                if (idle_cnt != IDLE_LIM) begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end else begin
                idle_cnt  <= '0;
                last_inst <= inst;
            end

            case (state)
                ST_COUNT: if (inst_match && idle_cnt == IDLE_M1) state <= ST_DONE;
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_COUNT;
            endcase
        end
    end

    // Once done, the trailing idle window is not part of the program run.
    assign cyc_adj = (cyc_cnt >= IDLE_W) ? (cyc_cnt - IDLE_W) : '0;

    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_next = ch_cnt[k];
        end
        if (rd_addr == ADDR_W'(NUM_CH)) begin
            rd_next = done ? cyc_adj : cyc_cnt;
        end
        if (rd_addr == ADDR_W'(NUM_CH + 1)) begin
            rd_next[STAT_DONE_BIT] = done;
            rd_next[STAT_OVF_BIT]  = |ovf;
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor -- randomized self-checking bench for perf_monitor.
//
// Built with CNT_W=8 so that overflow is reachable in a short run.
// Honors PERF_SAT_EN the same way the design does.

module tb_perf_monitor;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;
    localparam int IDLE   = 50;
    localparam int MAXV   = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic                CLK;
    logic                nrst;
    logic [31:0]         inst;
    logic [2*NUM_CH-1:0] evt_inc;
    logic                clr;
    logic [4:0]          rd_addr;
    logic [CNT_W-1:0]    rd_data;
    logic                done;
    logic [NUM_CH-1:0]   ovf;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    perf_monitor #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .CLK     (CLK),
        .nrst    (nrst),
        .inst    (inst),
        .evt_inc (evt_inc),
        .clr     (clr),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .done    (done),
        .ovf     (ovf)
    );

    // ---------------- reference model ----------------
    int unsigned       m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_ovf;
    int unsigned       m_cyc;
    bit                m_done;
    logic [31:0]       m_last;
    int                m_since;

    int          n_vec;
    int          n_err;
    logic [31:0] cur_inst;
    logic [CNT_W-1:0] exp_q[$];

    function automatic int unsigned model_add(input int unsigned v, input int unsigned a);
        int unsigned s;
        s = v + a;
        if (s > MAXV) begin
`ifdef PERF_SAT_EN
            return MAXV;
`else
            return s - (MAXV + 1);
`endif
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_cnt[k] = 0;
        m_ovf   = '0;
        m_cyc   = 0;
        m_done  = 1'b0;
        m_last  = '0;
        m_since = 0;
    endtask

    function automatic logic [CNT_W-1:0] model_read(input logic [4:0] a);
        if (a < NUM_CH) return CNT_W'(m_cnt[a]);
        if (a == NUM_CH) begin
            if (!m_done) return CNT_W'(m_cyc);
            return (m_cyc >= IDLE) ? CNT_W'(m_cyc - IDLE) : '0;
        end
        if (a == NUM_CH + 1) return CNT_W'({m_done, |m_ovf});
        return '0;
    endfunction

    task automatic model_update(input logic [31:0] i_v, input logic [2*NUM_CH-1:0] e_v,
                                input logic c_v);
        int unsigned a;
        if (c_v) begin
            model_reset();
            return;
        end
        if (!m_done) begin
            for (int k = 0; k < NUM_CH; k++) begin
                a = int'(e_v[2*k +: 2]);
                if (m_cnt[k] + a > MAXV) m_ovf[k] = 1'b1;
                m_cnt[k] = model_add(m_cnt[k], a);
            end
            m_cyc = model_add(m_cyc, 1);
        end
        // Program is finished once the instruction has been steady for IDLE cycles.
        if (i_v == m_last) begin
            m_since++;
        end else begin
            m_since = 0;
            m_last  = i_v;
        end
        if (m_since >= IDLE) m_done = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] fresh_inst();
        logic [31:0] r;
        r = $urandom;
        if (r == cur_inst) r = r + 32'd1;
        return r;
    endfunction

    // One clock: drive inputs, predict, then check all outputs after the edge.
    task automatic step(input logic [31:0] i_v, input logic [2*NUM_CH-1:0] e_v,
                        input logic c_v, input logic [4:0] a_v);
        logic [CNT_W-1:0] exp_rd;
        inst     = i_v;
        evt_inc  = e_v;
        clr      = c_v;
        rd_addr  = a_v;
        cur_inst = i_v;
        exp_q.push_back(model_read(a_v));
        model_update(i_v, e_v, c_v);
        @(posedge CLK);
        #1;
        exp_rd = exp_q.pop_front();
        n_vec++;
        if (rd_data !== exp_rd) begin
            n_err++;
            $display("FAIL rd_data addr=%0d: got %0d expected %0d", a_v, rd_data, exp_rd);
        end
        n_vec++;
        if (done !== m_done) begin
            n_err++;
            $display("FAIL done: got %0b expected %0b", done, m_done);
        end
        n_vec++;
        if (ovf !== m_ovf) begin
            n_err++;
            $display("FAIL ovf: got %0h expected %0h", ovf, m_ovf);
        end
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 5'd31;
        return 5'($urandom_range(0, NUM_CH + 2));
    endfunction

    // Asynchronous reset pulse between edges, checked before any clock edge.
    task automatic do_reset();
        #2;
        nrst = 1'b0;
        #1;
        n_vec++;
        if (rd_data !== '0) begin
            n_err++;
            $display("FAIL reset rd_data: got %0d expected 0", rd_data);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset done: got %0b expected 0", done);
        end
        n_vec++;
        if (ovf !== '0) begin
            n_err++;
            $display("FAIL reset ovf: got %0h expected 0", ovf);
        end
        model_reset();
        exp_q.delete();
        inst     = '0;
        evt_inc  = '0;
        clr      = 1'b0;
        rd_addr  = '0;
        cur_inst = '0;
        @(posedge CLK);
        #2;
        nrst = 1'b1;
    endtask

    // Hold the instruction until done rises; returns the number of held cycles.
    task automatic hold_until_done(output int held);
        held = -1;
        for (int k = 1; k <= 200; k++) begin
            step(cur_inst, 16'($urandom), 1'b0, rand_addr());
            if (done === 1'b1) begin
                held = k;
                break;
            end
        end
        if (held < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done timeout: got 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic read_check(input string name, input logic [4:0] a,
                              input logic [CNT_W-1:0] want);
        step(cur_inst, '0, 1'b0, a);
        n_vec++;
        if (rd_data !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, rd_data, want);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        for (int a = 0; a < NUM_CH + 3; a++) step('0, '0, 1'b0, 5'(a));
    endtask

    task automatic test_random();
        logic [31:0] iv;
        int held;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) hold_until_done(held);
            iv = ($urandom_range(0, 7) == 0) ? cur_inst : fresh_inst();
            step(iv, 16'($urandom), ($urandom_range(0, 39) == 0), rand_addr());
        end
    endtask

    task automatic test_idle_done();
        logic [31:0] iv;
        int held;
        int unsigned snap [NUM_CH];
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            if (i % 2 == 0) begin
                iv = 32'h0000_0013;
            end else begin
                iv = $urandom | 32'd1;
                if (iv == 32'h0000_0013) iv = 32'h0000_0015;
            end
            step(iv, 16'($urandom), 1'b0, rand_addr());
        end
        hold_until_done(held);
        n_vec++;
        if (held != IDLE) begin
            n_err++;
            $display("FAIL idle latency: got %0d expected %0d", held, IDLE);
        end
        read_check("cycle read in done", 5'(NUM_CH), 8'd100);
        // Activity while done must not leave DONE or move any counter.
        for (int k = 0; k < NUM_CH; k++) snap[k] = m_cnt[k];
        for (int n = 0; n < 20; n++) step(fresh_inst(), 16'($urandom) | 16'h5555, 1'b0, rand_addr());
        for (int k = 0; k < NUM_CH; k++) read_check("channel frozen", 5'(k), CNT_W'(snap[k]));
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL done held: got %0b expected 1", done);
        end
        do_reset();
        step(fresh_inst(), '0, 1'b0, 5'(NUM_CH + 1));
    endtask

    task automatic test_overflow();
        int held;
        logic [CNT_W-1:0] want0;
        do_reset();
        // Preload channels 0 and 2 to 250.
        for (int n = 0; n < 83; n++) step(fresh_inst(), 16'h0033, 1'b0, 5'd0);
        step(fresh_inst(), 16'h0011, 1'b0, 5'd0);
        read_check("preload ch0", 5'd0, 8'd250);
        for (int n = 0; n < 10; n++) step(fresh_inst(), 16'h0033, 1'b0, 5'd2);
        n_vec++;
        if (ovf[0] !== 1'b1 || ovf[2] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf after carry: got %0h expected bits 0 and 2 set", ovf);
        end
`ifdef PERF_SAT_EN
        want0 = 8'd255;
`else
        want0 = 8'(280 - 256);
`endif
        read_check("ch0 after overflow", 5'd0, want0);
        hold_until_done(held);
        read_check("status in done", 5'(NUM_CH + 1), 8'h03);
        read_check("out-of-range read", 5'd31, 8'h00);
    endtask

    task automatic test_clr_collision();
        int held;
        do_reset();
        for (int n = 0; n < 20; n++) step(fresh_inst(), 16'($urandom), 1'b0, rand_addr());
        hold_until_done(held);
        step(fresh_inst(), 16'hAAAA, 1'b1, 5'd0);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done after clr: got %0b expected 0", done);
        end
        n_vec++;
        if (ovf !== '0) begin
            n_err++;
            $display("FAIL ovf after clr: got %0h expected 0", ovf);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            step(fresh_inst(), '0, 1'b0, 5'(k));
            n_vec++;
            if (rd_data !== '0) begin
                n_err++;
                $display("FAIL ch%0d after clr: got %0d expected 0", k, rd_data);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 0; n < 30; n++) step(fresh_inst(), 16'h5555, 1'b0, 5'd1);
        do_reset();
        for (int k = 0; k < NUM_CH; k++) read_check("channel after reset", 5'(k), 8'd0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        nrst     = 1'b0;
        inst     = '0;
        evt_inc  = '0;
        clr      = 1'b0;
        rd_addr  = '0;
        cur_inst = '0;
        test_reset();
        test_random();
        test_idle_done();
        test_overflow();
        test_clr_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
